// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronised rx, oversampled 3-sample majority per bit,
// parity/framing/break detection, and a show-ahead FIFO of received frames.
module uart_rx_fifo #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       active,
    input  logic                       sample_tick,
    input  logic [1:0]                 frame_size,
    input  logic [1:0]                 parity_type,
    input  logic                       stop_type,
    input  logic                       rx,
    input  logic                       rd_en,
    input  logic                       ovf_clr,
    output logic [7:0]                 rd_data,
    output logic                       rd_perr,
    output logic                       rd_ferr,
    output logic                       rd_brk,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned CW  = $clog2(OVERSAMPLE);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = $clog2(DEPTH + 1);
    localparam int unsigned MID = OVERSAMPLE / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        s_a;
    logic        s_b;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [1:0]  cfg_fs;
    logic [1:0]  cfg_par;
    logic        cfg_stop;
    logic        perr_q;
    logic        ferr_q;
    logic        zero_q;

    logic        tick_dec_c;
    logic        tick_end_c;
    logic        maj_c;
    logic        fall_c;
    logic        par_en_c;
    logic        par_exp_c;
    logic        last_data_c;
    logic        push_c;
    entry_t      push_word_c;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
        end
    end

    // Bit-timing decodes and frame assembly helpers
    always_comb begin
        tick_dec_c       = sample_tick && (cnt == CW'(MID + 1));
        tick_end_c       = sample_tick && (cnt == CW'(OVERSAMPLE - 1));
        maj_c            = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
        fall_c           = rx_s_d & ~rx_s;
        par_en_c         = cfg_par[0] ^ cfg_par[1];
        par_exp_c        = (^shreg) ^ (cfg_par == 2'b10);
        last_data_c      = (bit_idx == (3'(cfg_fs) + 3'd4));
        push_c           = active && tick_dec_c &&
                           (((state == STOP1) && !cfg_stop) || (state == STOP2));
        push_word_c      = '0;
        push_word_c.brk  = zero_q & ~maj_c;
        push_word_c.ferr = ferr_q | ~maj_c;
        push_word_c.perr = perr_q;
        push_word_c.data = shreg;
    end

    // Receive FSM: bit counter, majority samples, shift register and error flags
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            s_a      <= 1'b1;
            s_b      <= 1'b1;
            bit_idx  <= '0;
            shreg    <= '0;
            cfg_fs   <= '0;
            cfg_par  <= '0;
            cfg_stop <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if ((state != IDLE) && !active) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            if ((state != IDLE) && sample_tick) begin
                cnt <= tick_end_c ? '0 : cnt + CW'(1);
                if (cnt == CW'(MID - 1)) s_a <= rx_s;
                if (cnt == CW'(MID))     s_b <= rx_s;
            end
            case (state)
                IDLE: begin
                    if (fall_c && active) begin
                        state    <= START;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        cfg_fs   <= frame_size;
                        cfg_par  <= parity_type;
                        cfg_stop <= stop_type;
                        bit_idx  <= '0;
                        shreg    <= '0;
                        perr_q   <= 1'b0;
                        ferr_q   <= 1'b0;
                        zero_q   <= 1'b1;
                    end
                end
                START: begin
                    if (tick_dec_c && maj_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (tick_end_c) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick_dec_c) begin
                        shreg[bit_idx] <= maj_c;
                        zero_q         <= zero_q & ~maj_c;
                    end
                    if (tick_end_c) begin
                        if (last_data_c) begin
                            bit_idx <= '0;
                            state   <= par_en_c ? PARITY : STOP1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_dec_c) begin
                        perr_q <= maj_c ^ par_exp_c;
                        zero_q <= zero_q & ~maj_c;
                    end
                    if (tick_end_c) state <= STOP1;
                end
                STOP1: begin
                    if (tick_dec_c && !cfg_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        if (tick_dec_c) begin
                            ferr_q <= ferr_q | ~maj_c;
                            zero_q <= zero_q & ~maj_c;
                        end
                        if (tick_end_c) state <= STOP2;
                    end
                end
                STOP2: begin
                    if (tick_dec_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    entry_t        head_q;

    logic          do_pop_c;
    logic          do_push_c;
    logic          ovf_set_c;
    logic [LW-1:0] count_nxt_c;
    entry_t        head_nxt_c;

    // Push/pop arbitration and next head for the show-ahead output register
    always_comb begin
        do_pop_c    = rd_en && !empty;
        do_push_c   = push_c && (!full || do_pop_c);
        ovf_set_c   = push_c && full && !do_pop_c;
        count_nxt_c = count;
        if (do_push_c && !do_pop_c) count_nxt_c = count + LW'(1);
        if (!do_push_c && do_pop_c) count_nxt_c = count - LW'(1);
        head_nxt_c = head_q;
        if (count_nxt_c == '0) begin
            head_nxt_c = '0;
        end else if (do_pop_c) begin
            head_nxt_c = (count == LW'(1)) ? push_word_c : mem[rd_ptr + AW'(1)];
        end else if (empty && do_push_c) begin
            head_nxt_c = push_word_c;
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= push_word_c;
    end

    // Pointers, occupancy, flags and head register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            head_q   <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_nxt_c;
            empty  <= (count_nxt_c == '0);
            full   <= (count_nxt_c == LW'(DEPTH));
            head_q <= head_nxt_c;
            if (ovf_set_c)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign rd_data = head_q.data;
    assign rd_perr = head_q.perr;
    assign rd_ferr = head_q.ferr;
    assign rd_brk  = head_q.brk;
    assign level   = count;

endmodule
